// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch stage and anything that traces it:
//   WORD_SIZE      - architectural address / PC width
//   INSTR_SIZE     - fetched instruction word width
//   RESET_VECTOR   - default PC loaded after reset
//   fetch_state_t  - fetch FSM state encoding (also used by debug/trace)
//   next_pc()      - sequential PC advance, wraps modulo 2^WORD_SIZE
//   pc_misaligned()- true when a PC is not word aligned
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int WORD_SIZE = 32;
    localparam int INSTR_SIZE = 32;
    localparam logic [WORD_SIZE-1:0] RESET_VECTOR = '0;

    typedef enum logic [2:0] {
        FS_BOOT  = 3'd0,
        FS_ISSUE = 3'd1,
        FS_REQ   = 3'd2,
        FS_DRAIN = 3'd3,
        FS_HOLD  = 3'd4,
        FS_FAULT = 3'd5
    } fetch_state_t;

    // Plain modular add: 0xFFFFFFFC advances to 0x00000000.
    function automatic logic [WORD_SIZE-1:0] next_pc(input logic [WORD_SIZE-1:0] pc);
        return pc + WORD_SIZE'(4);
    endfunction

    function automatic logic pc_misaligned(input logic [WORD_SIZE-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage sitting in front of the register file's PC path. It loads the
// PC, reads one instruction word at a time over a req/ack bus and hands it to
// decode with a valid/ready handshake. Redirects from execute and bus errors /
// misaligned PCs are handled here.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_program_counter                  current PC from the register file
//   o_load_pc, o_load_pc_data          PC load enable / value
//   i_redirect, i_redirect_target      control-flow redirect from execute
//   o_mem_req, o_mem_addr              instruction-memory read request
//   i_mem_ack, i_mem_err, i_mem_data   read completion (ack or error)
//   o_instr_valid, o_instr, o_instr_pc instruction to decode
//   i_instr_ready                      decode accepts the instruction
//   o_fetch_fault                      sticky fault; o_instr_pc = fault address
// ----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] reset_vector = RESET_VECTOR,
    parameter int                   instr_size   = INSTR_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WORD_SIZE-1:0]  i_program_counter,
    output logic                  o_load_pc,
    output logic [WORD_SIZE-1:0]  o_load_pc_data,
    input  logic                  i_redirect,
    input  logic [WORD_SIZE-1:0]  i_redirect_target,
    output logic                  o_mem_req,
    output logic [WORD_SIZE-1:0]  o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic                  i_mem_err,
    input  logic [instr_size-1:0] i_mem_data,
    output logic                  o_instr_valid,
    output logic [instr_size-1:0] o_instr,
    output logic [WORD_SIZE-1:0]  o_instr_pc,
    input  logic                  i_instr_ready,
    output logic                  o_fetch_fault
);

    fetch_state_t            state_reg, state_next;
    logic [WORD_SIZE-1:0]    fetch_addr_reg;
    logic [instr_size-1:0]   instr_reg;
    logic [WORD_SIZE-1:0]    instr_pc_reg;

    // Datapath strobes decoded alongside the next-state logic.
    logic                    capture_instr;
    logic                    capture_fault;
    logic [WORD_SIZE-1:0]    fault_addr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= FS_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        capture_instr = 1'b0;
        capture_fault = 1'b0;
        fault_addr    = fetch_addr_reg;
        case (state_reg)
            FS_BOOT: begin
                state_next = FS_ISSUE;
            end
            FS_ISSUE: begin
                // A redirect here means the PC changes at this edge; sample it
                // again next cycle instead of fetching the stale value.
                if (!i_redirect) begin
                    if (pc_misaligned(i_program_counter)) begin
                        state_next    = FS_FAULT;
                        capture_fault = 1'b1;
                        fault_addr    = i_program_counter;
                    end else begin
                        state_next = FS_REQ;
                    end
                end
            end
            FS_REQ: begin
                if (i_redirect) begin
                    // Completion in the same cycle is simply dropped; otherwise
                    // the outstanding read must be drained before refetching.
                    state_next = (i_mem_ack || i_mem_err) ? FS_ISSUE : FS_DRAIN;
                end else if (i_mem_ack) begin
                    state_next    = FS_HOLD;
                    capture_instr = 1'b1;
                end else if (i_mem_err) begin
                    state_next    = FS_FAULT;
                    capture_fault = 1'b1;
                end
            end
            FS_DRAIN: begin
                if (i_mem_ack || i_mem_err) begin
                    state_next = FS_ISSUE;
                end
            end
            FS_HOLD: begin
                if (i_redirect || i_instr_ready) begin
                    state_next = FS_ISSUE;
                end
            end
            FS_FAULT: begin
                if (i_redirect) begin
                    state_next = FS_ISSUE;
                end
            end
            default: begin
                state_next = FS_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch address and instruction payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_addr_reg <= '0;
            instr_reg      <= '0;
            instr_pc_reg   <= '0;
        end else begin
            if (state_reg == FS_ISSUE) begin
                fetch_addr_reg <= i_program_counter;
            end
            if (capture_instr) begin
                instr_reg    <= i_mem_data;
                instr_pc_reg <= fetch_addr_reg;
            end else if (capture_fault) begin
                instr_pc_reg <= fault_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_load_pc      = 1'b0;
        o_load_pc_data = '0;
        o_mem_req      = 1'b0;
        o_instr_valid  = 1'b0;
        o_fetch_fault  = 1'b0;
        if (!i_rst) begin
            o_mem_req     = (state_reg == FS_REQ) || (state_reg == FS_DRAIN);
            o_instr_valid = (state_reg == FS_HOLD);
            o_fetch_fault = (state_reg == FS_FAULT);
            if (state_reg == FS_BOOT) begin
                // Redirects are ignored while booting.
                o_load_pc      = 1'b1;
                o_load_pc_data = reset_vector;
            end else if (i_redirect) begin
                o_load_pc      = 1'b1;
                o_load_pc_data = i_redirect_target;
            end else if (state_reg == FS_REQ && i_mem_ack) begin
                o_load_pc      = 1'b1;
                o_load_pc_data = next_pc(fetch_addr_reg);
            end
        end
    end

    assign o_mem_addr = fetch_addr_reg;
    assign o_instr    = instr_reg;
    assign o_instr_pc = instr_pc_reg;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of register_file's program-counter path.
- Consumes the program counter output.
- Drives the PC load enable and data.
- Issues instruction-memory reads over a req/ack bus.
- Presents one fetched instruction at a time to decode with a valid/ready handshake.
- Handles control-flow redirects from execute and bus error / misalignment faults.

Parameters:
reset_vector, 0, PC value loaded on the first cycle after reset.
instr_size, 32, width of a fetched instruction word in bits.

Ports:
i_clk  input  1  clock, positive edge.
i_rst  input  1  reset, synchronous, active-high.
i_program_counter  input  WORD_SIZE  current PC from the register file.
o_load_pc  output  1  PC load enable to the register file.
o_load_pc_data  output  WORD_SIZE  value to load into the PC.
i_redirect  input  1  taken branch/jump/trap from execute.
i_redirect_target  input  WORD_SIZE  redirect destination.
o_mem_req  output  1  instruction-memory read request.
o_mem_addr  output  WORD_SIZE  read address; stable while o_mem_req is high.
i_mem_ack  input  1  read complete; i_mem_data valid this cycle.
i_mem_err  input  1  read failed; completes the request like ack.
i_mem_data  input  instr_size  read data.
o_instr_valid  output  1  o_instr/o_instr_pc valid for decode.
o_instr  output  instr_size  fetched instruction.
o_instr_pc  output  WORD_SIZE  address of o_instr.
i_instr_ready  input  1  decode accepts the instruction.
o_fetch_fault  output  1  sticky fetch fault indication.

Behaviour:
Reset and state machine
- Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high.
- While i_rst is high: state=BOOT; o_mem_req=0, o_instr_valid=0, o_fetch_fault=0, o_load_pc=0; o_instr, o_instr_pc and fetch_addr cleared to 0.
- States: BOOT, ISSUE, REQ, DRAIN, HOLD, FAULT.
- BOOT (first cycle after reset release): o_load_pc=1, data=reset_vector; goes to ISSUE.
- ISSUE:
  - fetch_addr <= i_program_counter, reflecting any PC load from the previous edge.
  - If i_program_counter[1:0]!=0: go to FAULT with no request issued.
  - Otherwise go to REQ.
  - o_mem_req=0 in ISSUE.
- REQ: o_mem_req=1, o_mem_addr=fetch_addr.
  - On ack: o_instr<=i_mem_data, o_instr_pc<=fetch_addr, o_instr_valid<=1; same cycle o_load_pc=1, data=fetch_addr+4; go to HOLD.
  - On err, no ack: go to FAULT.
- HOLD: o_instr_valid=1 and payload stable until i_instr_ready=1, then ISSUE.
- Minimum throughput is one instruction per 3 cycles (ISSUE, REQ, HOLD). Memory latency adds cycles in REQ.
- PC+4 wraps modulo 2^WORD_SIZE: 0xFFFFFFFC advances to 0x00000000.

Redirect (i_redirect=1)
- Always: o_load_pc=1, data=i_redirect_target. Redirect takes priority over the PC+4 load.
- ISSUE: stay in ISSUE; the new PC is sampled next cycle.
- REQ with ack or err the same cycle: discard data/err and go to ISSUE.
- REQ without ack: go to DRAIN.
- DRAIN: o_mem_req stays 1 with the old fetch_addr until ack or err, which is discarded, then ISSUE. A further redirect in DRAIN reloads the PC and stays in DRAIN.
- HOLD: o_instr_valid drops next cycle, go to ISSUE. If i_instr_ready is also 1, the instruction counts as consumed.
- FAULT: clears o_fetch_fault and goes to ISSUE (trap entry path).
- BOOT: redirect is ignored; reset_vector is loaded.

Fault
- FAULT: o_fetch_fault=1, o_fetch_fault_pc held in o_instr_pc (the fault address), o_instr_valid=0, o_mem_req=0.
- Held until a redirect or reset.

Other rules
- Memory acks outside REQ/DRAIN are ignored.
- Reset mid-transaction abandons the request immediately: o_mem_req=0 on the next edge.

Decomposition:
- Shared defaults (`include "defaults/defaults.sv"`): WORD_SIZE, new INSTR_SIZE=32, RESET_VECTOR default.
- Shared core package: fetch_state_t enum for the six states, used by core debug/trace.
- No sub-module; next-PC adder and FSM live inline.

Test Plan:
1. Reset held 3 cycles, then released with reset_vector=0x100 -> o_load_pc pulses with 0x100; o_mem_addr=0x100 two cycles later; all outputs 0 during reset.
2. Normal fetch with ack latency 2, data 0x00500093, ready=1 -> o_instr=0x00500093, o_instr_pc=0x100, PC loaded 0x104, next o_mem_addr=0x104.
3. Back-pressure: ready low 5 cycles -> o_instr_valid/payload stable for 5 cycles, no new o_mem_req until ready.
4. Redirect to 0x200 during REQ with ack delayed 4 cycles -> o_mem_addr stays at the old address until ack, data discarded, o_instr_valid never asserted, next request to 0x200.
5. i_mem_err at 0x108 -> o_fetch_fault=1, o_instr_pc=0x108, no requests. Then redirect to 0x40 -> fault clears, fetch from 0x40.
6. Redirect to 0x202 -> FAULT without any o_mem_req. Separately, fetch at 0xFFFFFFFC -> PC loaded 0x00000000.
